// File: rtl/spi_cfg_master.sv
// SPI master for the daisy-chained configuration shift registers.
// Shifts wdata out MSB-first, loads cfg on cs_b rise, returns the shifted-out bits.
module spi_cfg_master #(
   parameter int NBYTES = 1,
   parameter int DIV    = 2,
   parameter int CS_GAP = 2
) (
   input  logic                  sclk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   wdata,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   rdata,
   output logic                  spi_sck,
   output logic                  spi_sdi,
   output logic                  spi_cs_b,
   input  logic                  spi_sdo
);

   localparam int NBITS = 8 * NBYTES;
   localparam int BW    = $clog2(NBITS + 1);
   localparam int CMAX  = (DIV > CS_GAP) ? DIV : CS_GAP;
   localparam int CW    = $clog2(CMAX + 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SETUP    = 3'd1;
   localparam logic [2:0] SHIFT_HI = 3'd2;
   localparam logic [2:0] SHIFT_LO = 3'd3;
   localparam logic [2:0] GAP      = 3'd4;

   logic [2:0]       state;
   logic [NBITS-1:0] tx;
   logic [NBITS-1:0] rx;
   logic [BW-1:0]    bitcnt;
   logic [CW-1:0]    divcnt;
   logic             div_end;
   logic             gap_end;
   logic             last_bit;

   assign div_end  = (divcnt == CW'(DIV - 1));
   assign gap_end  = (divcnt == CW'(CS_GAP - 1));
   assign last_bit = (bitcnt == BW'(NBITS - 1));

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx       <= '0;
         rx       <= '0;
         bitcnt   <= '0;
         divcnt   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rdata    <= '0;
         spi_sck  <= 1'b0;
         spi_sdi  <= 1'b0;
         spi_cs_b <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  tx       <= wdata;
                  rx       <= '0;
                  bitcnt   <= '0;
                  divcnt   <= '0;
                  busy     <= 1'b1;
                  spi_cs_b <= 1'b0;
                  spi_sdi  <= wdata[NBITS-1];
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (div_end) begin
                  divcnt  <= '0;
                  spi_sck <= 1'b1;
                  rx      <= {rx[NBITS-2:0], spi_sdo};
                  state   <= SHIFT_HI;
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (div_end) begin
                  divcnt  <= '0;
                  spi_sck <= 1'b0;
                  bitcnt  <= bitcnt + 1'b1;
                  state   <= SHIFT_LO;
                  if (!last_bit) begin
                     tx      <= {tx[NBITS-2:0], 1'b0};
                     spi_sdi <= tx[NBITS-2];
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            SHIFT_LO: begin
               if (div_end) begin
                  divcnt <= '0;
                  // after the final bit this low half is the cs_b hold time
                  if (bitcnt == BW'(NBITS)) begin
                     spi_cs_b <= 1'b1;
                     spi_sdi  <= 1'b0;
                     rdata    <= rx;
                     state    <= GAP;
                  end else begin
                     spi_sck <= 1'b1;
                     rx      <= {rx[NBITS-2:0], spi_sdo};
                     state   <= SHIFT_HI;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_end) begin
                  divcnt <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= IDLE;
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: 1-byte and 2-byte chains modelled behaviourally.
// Directed frames with hand-computed cfg, readback and timing.
module tb_spi_cfg_master;

   logic        sclk = 1'b0;
   logic        rst  = 1'b1;

   logic        start1 = 1'b0;
   logic [7:0]  wdata1 = '0;
   logic        busy1, done1, sck1, sdi1, cs1, sdo1;
   logic [7:0]  rdata1;

   logic        start2 = 1'b0;
   logic [15:0] wdata2 = '0;
   logic        busy2, done2, sck2, sdi2, cs2, sdo2;
   logic [15:0] rdata2;

   int pass_cnt = 0;
   int total    = 0;

   always #5 sclk = ~sclk;

   spi_cfg_master #(.NBYTES(1), .DIV(2), .CS_GAP(2)) u1 (
      .sclk(sclk), .rst(rst), .start(start1), .wdata(wdata1),
      .busy(busy1), .done(done1), .rdata(rdata1),
      .spi_sck(sck1), .spi_sdi(sdi1), .spi_cs_b(cs1), .spi_sdo(sdo1)
   );

   spi_cfg_master #(.NBYTES(2), .DIV(2), .CS_GAP(2)) u2 (
      .sclk(sclk), .rst(rst), .start(start2), .wdata(wdata2),
      .busy(busy2), .done(done2), .rdata(rdata2),
      .spi_sck(sck2), .spi_sdi(sdi2), .spi_cs_b(cs2), .spi_sdo(sdo2)
   );

   // chain models: shift on sck rise, load cfg on cs_b rise
   logic [7:0]  ch1, cfg1;
   logic [15:0] ch2, cfg2;

   always @(posedge sck1 or posedge rst)
      if (rst) ch1 <= '0;
      else     ch1 <= {ch1[6:0], sdi1};
   always @(posedge cs1 or posedge rst)
      if (rst) cfg1 <= '0;
      else     cfg1 <= ch1;
   assign sdo1 = ch1[7];

   always @(posedge sck2 or posedge rst)
      if (rst) ch2 <= '0;
      else     ch2 <= {ch2[14:0], sdi2};
   always @(posedge cs2 or posedge rst)
      if (rst) cfg2 <= '0;
      else     cfg2 <= ch2;
   assign sdo2 = ch2[15];

   task automatic run1(input logic [7:0] w, input int pulse_at,
                       output int cslow, output int rises, output int dw);
      logic prev;
      logic pulsed;
      cslow  = 0;
      rises  = 0;
      dw     = 0;
      prev   = 1'b0;
      pulsed = 1'b0;
      @(negedge sclk);
      wdata1 = w;
      start1 = 1'b1;
      @(negedge sclk);
      start1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!cs1) cslow++;
         if (sck1 && !prev) rises++;
         prev = sck1;
         if (done1) dw++;
         if (dw > 0 && !done1) break;
         if (start1) start1 = 1'b0;
         if (!pulsed && rises == pulse_at) begin
            pulsed = 1'b1;
            start1 = 1'b1;
            wdata1 = 8'hFF;
         end
         @(negedge sclk);
      end
      start1 = 1'b0;
   endtask

   task automatic run2(input logic [15:0] w, output int cslow, output int dw);
      cslow = 0;
      dw    = 0;
      @(negedge sclk);
      wdata2 = w;
      start2 = 1'b1;
      @(negedge sclk);
      start2 = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!cs2) cslow++;
         if (done2) dw++;
         if (dw > 0 && !done2) break;
         @(negedge sclk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge sclk);
      rst = 1'b0;
      @(negedge sclk);
      total++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else pass_cnt++;
      total++; if (done1 !== 1'b0) $display("FAIL reset_done got %b want 0", done1); else pass_cnt++;
      total++; if (cs1 !== 1'b1) $display("FAIL reset_cs got %b want 1", cs1); else pass_cnt++;
      total++; if (sck1 !== 1'b0) $display("FAIL reset_sck got %b want 0", sck1); else pass_cnt++;
      total++; if (sdi1 !== 1'b0) $display("FAIL reset_sdi got %b want 0", sdi1); else pass_cnt++;
      total++; if (rdata1 !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata1); else pass_cnt++;
   endtask

   task automatic test_single_frame;
      int cl, rs, dw;
      run1(8'hA5, -1, cl, rs, dw);
      total++; if (cfg1 !== 8'hA5) $display("FAIL f1_cfg got %h want a5", cfg1); else pass_cnt++;
      total++; if (rdata1 !== 8'h00) $display("FAIL f1_rdata got %h want 00", rdata1); else pass_cnt++;
      total++; if (cl !== 34) $display("FAIL f1_cslow got %0d want 34", cl); else pass_cnt++;
      total++; if (rs !== 8) $display("FAIL f1_rises got %0d want 8", rs); else pass_cnt++;
      run1(8'h3C, -1, cl, rs, dw);
      total++; if (cfg1 !== 8'h3C) $display("FAIL f2_cfg got %h want 3c", cfg1); else pass_cnt++;
      total++; if (rdata1 !== 8'hA5) $display("FAIL f2_rdata got %h want a5", rdata1); else pass_cnt++;
      total++; if (dw !== 1) $display("FAIL f2_done_width got %0d want 1", dw); else pass_cnt++;
   endtask

   task automatic test_chain2;
      int cl, dw;
      run2(16'h1234, cl, dw);
      total++; if (cfg2[15:8] !== 8'h12) $display("FAIL c2_far got %h want 12", cfg2[15:8]); else pass_cnt++;
      total++; if (cfg2[7:0] !== 8'h34) $display("FAIL c2_near got %h want 34", cfg2[7:0]); else pass_cnt++;
      total++; if (cl !== 66) $display("FAIL c2_cslow got %0d want 66", cl); else pass_cnt++;
      run2(16'hBEEF, cl, dw);
      total++; if (rdata2 !== 16'h1234) $display("FAIL c2_rdata got %h want 1234", rdata2); else pass_cnt++;
      total++; if (cfg2 !== 16'hBEEF) $display("FAIL c2_cfg2 got %h want beef", cfg2); else pass_cnt++;
      total++; if (dw !== 1) $display("FAIL c2_done_width got %0d want 1", dw); else pass_cnt++;
   endtask

   task automatic test_start_ignored;
      int cl, rs, dw;
      int extra;
      run1(8'h5A, 3, cl, rs, dw);
      total++; if (cfg1 !== 8'h5A) $display("FAIL ign_cfg got %h want 5a", cfg1); else pass_cnt++;
      total++; if (rdata1 !== 8'h3C) $display("FAIL ign_rdata got %h want 3c", rdata1); else pass_cnt++;
      total++; if (cl !== 34) $display("FAIL ign_cslow got %0d want 34", cl); else pass_cnt++;
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy1 || !cs1) extra++;
         @(negedge sclk);
      end
      total++; if (extra !== 0) $display("FAIL ign_queued got %0d busy cycles want 0", extra); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int dn, hi;
      logic lowseen, second, drop;
      logic [7:0] r_first;
      dn = 0; hi = 0; lowseen = 0; second = 0; drop = 0; r_first = '0;
      @(negedge sclk);
      wdata1 = 8'h81;
      start1 = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge sclk);
         if (drop) begin start1 = 1'b0; drop = 1'b0; end
         if (!cs1) begin
            if (hi > 0) second = 1'b1;
            lowseen = 1'b1;
         end else if (lowseen && !second) begin
            hi++;
         end
         if (done1) begin
            dn++;
            if (dn == 1) begin r_first = rdata1; drop = 1'b1; end
            if (dn == 2) break;
         end
      end
      start1 = 1'b0;
      @(negedge sclk);
      total++; if (hi !== 3) $display("FAIL b2b_gap got %0d want 3", hi); else pass_cnt++;
      total++; if (r_first !== 8'h5A) $display("FAIL b2b_rdata1 got %h want 5a", r_first); else pass_cnt++;
      total++; if (rdata1 !== 8'h81) $display("FAIL b2b_rdata2 got %h want 81", rdata1); else pass_cnt++;
      total++; if (dn !== 2) $display("FAIL b2b_frames got %0d want 2", dn); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame;
      int rs, cl, dw;
      logic prev;
      rs = 0; prev = 1'b0;
      @(negedge sclk);
      wdata1 = 8'hC3;
      start1 = 1'b1;
      @(negedge sclk);
      start1 = 1'b0;
      for (int i = 0; i < 100 && rs < 4; i++) begin
         if (sck1 && !prev) rs++;
         prev = sck1;
         @(negedge sclk);
      end
      rst = 1'b1;
      #1;
      total++; if (cs1 !== 1'b1) $display("FAIL mid_rst_cs got %b want 1", cs1); else pass_cnt++;
      total++; if (sck1 !== 1'b0) $display("FAIL mid_rst_sck got %b want 0", sck1); else pass_cnt++;
      total++; if (busy1 !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy1); else pass_cnt++;
      total++; if (rdata1 !== 8'h00) $display("FAIL mid_rst_rdata got %h want 00", rdata1); else pass_cnt++;
      @(negedge sclk);
      rst = 1'b0;
      run1(8'h77, -1, cl, rs, dw);
      total++; if (cfg1 !== 8'h77) $display("FAIL post_rst_cfg got %h want 77", cfg1); else pass_cnt++;
      total++; if (rdata1 !== 8'h00) $display("FAIL post_rst_rdata got %h want 00", rdata1); else pass_cnt++;
      total++; if (cl !== 34) $display("FAIL post_rst_cslow got %0d want 34", cl); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_chain2;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid_frame;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
